conv_output: RTL and testbench

- Output-reorder stage placed after the systolic convolution array.
- The array emits 64-bit words. Each word holds 8 signed 8-bit output channels of one pixel, in channel-group-major order: all pixels of channel group 0, then all pixels of group 1, and so on.
- conv_output buffers one whole feature map. It then streams the map out in pixel-major (HWC) order: for each pixel, groups 0..G-1.

---
 rtl/conv_output_pkg.sv | 25 ++
 rtl/conv_output_ram.sv | 46 ++++
 rtl/conv_output.sv | 208 ++++++++++++++++++++
 tb/tb_conv_output.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_output_pkg.sv
// -----------------------------------------------------------------------------
// conv_output_pkg
// Shared constants and types for the convolution output-reorder stage.
//   DATA_W    : stream word width (8 channels x 8 bits)
//   BUF_DEPTH : reorder buffer depth in words
//   DIM_W     : width of the layer configuration inputs
//   CNT_W     : width of pixel/word counters (products of two DIM_W values)
//   ADDR_W    : buffer address width
//   state_t   : control FSM states
// -----------------------------------------------------------------------------
package conv_output_pkg;

    localparam int DATA_W    = 64;
    localparam int BUF_DEPTH = 1024;
    localparam int DIM_W     = 16;
    localparam int CNT_W     = 2 * DIM_W;
    localparam int ADDR_W    = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/conv_output_ram.sv
// -----------------------------------------------------------------------------
// conv_output_ram
// Simple dual-port buffer: one write port, one read port, registered read with
// one cycle of latency. The read register holds its value while i_re is low,
// so a fetched word can wait there until the output stage takes it.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable
//   i_raddr  : read address
//   o_rdata  : read data, valid the cycle after i_re
// -----------------------------------------------------------------------------
module conv_output_ram
    import conv_output_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [BUF_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds the last word when not reading
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_output.sv
// -----------------------------------------------------------------------------
// conv_output
// Reorders one feature map from channel-group-major order (as produced by the
// systolic array) into pixel-major HWC order. The whole map is written into a
// buffer at address pix*G+grp, then read out linearly.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : one-cycle pulse in IDLE that begins a layer
//   In_Channel         : channel count (multiple of 8)
//   Matrix_Col/Row     : feature-map width/height in pixels
//   sData/sValid/sReady: input stream (ready only while filling)
//   mData_payload/mData_valid/mData_ready : output stream
// -----------------------------------------------------------------------------
module conv_output
    import conv_output_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  In_Channel,
    input  logic [DIM_W-1:0]  Matrix_Col,
    input  logic [DIM_W-1:0]  Matrix_Row,
    input  logic [DATA_W-1:0] sData,
    input  logic              sValid,
    output logic              sReady,
    output logic [DATA_W-1:0] mData_payload,
    output logic              mData_valid,
    input  logic              mData_ready
);

    state_t             r_state;
    state_t             w_state_next;

    logic [DIM_W-1:0]   r_g;        // channel groups
    logic [CNT_W-1:0]   r_p;        // pixels
    logic [CNT_W-1:0]   r_n;        // total words
    logic [DIM_W-1:0]   r_grp;      // current write group
    logic [CNT_W-1:0]   r_pix;      // current write pixel
    logic [CNT_W-1:0]   r_wbase;    // running pix*G, avoids a per-beat multiply
    logic [CNT_W-1:0]   r_wcnt;     // words accepted
    logic [CNT_W-1:0]   r_raddr;    // next read address / reads issued
    logic [CNT_W-1:0]   r_ocnt;     // words delivered
    logic               r_rd_pend;  // RAM read register holds an undelivered word
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;

    logic [DIM_W-1:0]   w_cfg_g;
    logic [CNT_W-1:0]   w_cfg_p;
    logic [CNT_W-1:0]   w_cfg_n;
    logic [CNT_W-1:0]   w_waddr_full;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_start;
    logic               w_wr;
    logic               w_wr_last;
    logic               w_pix_wrap;
    logic               w_accept;
    logic               w_out_last;
    logic               w_load;
    logic               w_re;
    logic               w_unused;

    assign w_cfg_g      = {3'b000, In_Channel[DIM_W-1:3]};
    assign w_cfg_p      = CNT_W'(Matrix_Row) * CNT_W'(Matrix_Col);
    assign w_cfg_n      = CNT_W'(w_cfg_g) * w_cfg_p;

    assign w_start      = (r_state == IDLE) && start;
    assign sReady       = (r_state == FILL);
    assign w_wr         = sValid && (r_state == FILL);
    assign w_wr_last    = w_wr && (r_wcnt == (r_n - CNT_W'(1)));
    assign w_pix_wrap   = (r_pix == (r_p - CNT_W'(1)));
    assign w_waddr_full = r_wbase + CNT_W'(r_grp);

    assign w_accept     = r_out_valid && mData_ready;
    assign w_out_last   = w_accept && (r_ocnt == (r_n - CNT_W'(1)));
    // Fetched word moves to the output register when that register is free
    // or its current word is being taken this cycle.
    assign w_load       = r_rd_pend && (!r_out_valid || mData_ready);
    // Issue a read only if the RAM read register will be free at the edge,
    // so backpressure never overwrites an undelivered word.
    assign w_re         = (r_state == DRAIN) && (r_raddr < r_n) && (!r_rd_pend || w_load);

    assign w_unused     = ^{In_Channel[2:0], w_waddr_full[CNT_W-1:ADDR_W]};

    conv_output_ram u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (w_waddr_full[ADDR_W-1:0]),
        .i_wdata (sData),
        .i_re    (w_re),
        .i_raddr (r_raddr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FILL;
                end else begin
                    w_state_next = IDLE;
                end
            end
            FILL: begin
                if (w_wr_last) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = FILL;
                end
            end
            DRAIN: begin
                if (w_out_last) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Layer configuration latch and address/word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g     <= '0;
            r_p     <= '0;
            r_n     <= '0;
            r_grp   <= '0;
            r_pix   <= '0;
            r_wbase <= '0;
            r_wcnt  <= '0;
            r_raddr <= '0;
            r_ocnt  <= '0;
        end else if (w_start) begin
            r_g     <= w_cfg_g;
            r_p     <= w_cfg_p;
            r_n     <= w_cfg_n;
            r_grp   <= '0;
            r_pix   <= '0;
            r_wbase <= '0;
            r_wcnt  <= '0;
            r_raddr <= '0;
            r_ocnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
                if (w_pix_wrap) begin
                    r_pix   <= '0;
                    r_wbase <= '0;
                    r_grp   <= r_grp + DIM_W'(1);
                end else begin
                    r_pix   <= r_pix + CNT_W'(1);
                    r_wbase <= r_wbase + CNT_W'(r_g);
                end
            end
            if (w_re) begin
                r_raddr <= r_raddr + CNT_W'(1);
            end
            if (w_accept) begin
                r_ocnt <= r_ocnt + CNT_W'(1);
            end
        end
    end

    // Tracks whether the RAM read register holds a word not yet delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
        end else if (w_re) begin
            r_rd_pend <= 1'b1;
        end else if (w_load) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= r_rd_pend;
        end
    end

    // Output register; payload is held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rdata;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign mData_valid   = r_out_valid;
    assign mData_payload = r_out_data;

endmodule

// File: tb/tb_conv_output.sv
module tb_conv_output;
    import conv_output_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  In_Channel;
    logic [DIM_W-1:0]  Matrix_Col;
    logic [DIM_W-1:0]  Matrix_Row;
    logic [DATA_W-1:0] sData;
    logic              sValid;
    logic              sReady;
    logic [DATA_W-1:0] mData_payload;
    logic              mData_valid;
    logic              mData_ready;

    int vectors     = 0;
    int miscompares = 0;
    int out_cnt     = 0;
    bit rand_ready  = 1'b0;

    logic [63:0] in_words [0:1023];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    conv_output dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .In_Channel    (In_Channel),
        .Matrix_Col    (Matrix_Col),
        .Matrix_Row    (Matrix_Row),
        .sData         (sData),
        .sValid        (sValid),
        .sReady        (sReady),
        .mData_payload (mData_payload),
        .mData_valid   (mData_valid),
        .mData_ready   (mData_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Output scoreboard: every valid cycle must show the word at the head of
    // the expected queue (this also proves the payload holds while stalled).
    always @(negedge clk) begin
        if (!rst && mData_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_word: got %0h, want no word", mData_payload);
            end else begin
                check("payload", mData_payload, exp_q[0]);
                if (mData_ready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                end
            end
        end
    end

    // Output-side ready: held high or toggled randomly
    initial begin
        mData_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mData_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: input word k (grp=k/P, pix=k%P) lands at output pix*G+grp
    task automatic build_expected(input int g, input int p);
        logic [63:0] tmp [0:1023];
        exp_q.delete();
        for (int k = 0; k < g * p; k++) begin
            tmp[(k % p) * g + (k / p)] = in_words[k];
        end
        for (int j = 0; j < g * p; j++) begin
            exp_q.push_back(tmp[j]);
        end
    endtask

    task automatic pulse_start(input int ic, input int col, input int row);
        In_Channel = 16'(ic);
        Matrix_Col = 16'(col);
        Matrix_Row = 16'(row);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Different values afterwards: a DUT that resamples would misbehave
        In_Channel = 16'd8;
        Matrix_Col = 16'd1;
        Matrix_Row = 16'd1;
    endtask

    task automatic send_words(input int n, input bit gaps, input int start_at);
        int k = 0;
        int cyc = 0;
        bit pulsed = 1'b0;
        while (k < n && cyc < 20000) begin
            sValid = !gaps || (cyc % 3 == 0);
            sData  = in_words[k];
            start  = !pulsed && (k == start_at);
            if (start) pulsed = 1'b1;
            @(negedge clk);
            if (sValid && sReady) k++;
            tick();
            cyc++;
        end
        sValid = 1'b0;
        start  = 1'b0;
        check("words_in", 64'(k), 64'(n));
    endtask

    task automatic wait_drain(input int n, input int start_cyc);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            start = (cyc == start_cyc);
            @(negedge clk);
            tick();
            start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("valid_after_last", 64'(mData_valid), 64'd0);
        check("sready_after_last", 64'(sReady), 64'd0);
        check("words_out", 64'(out_cnt), 64'(n));
        tick();
    endtask

    task automatic run_layer(input int ic, input int col, input int row, input bit gaps,
                             input bit rr, input int fill_start_at, input int drain_start_cyc);
        int g = ic / 8;
        int p = col * row;
        out_cnt = 0;
        build_expected(g, p);
        rand_ready = rr;
        pulse_start(ic, col, row);
        send_words(g * p, gaps, fill_start_at);
        wait_drain(g * p, drain_start_cyc);
        rand_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        sValid     = 1'b0;
        sData      = '0;
        In_Channel = '0;
        Matrix_Col = '0;
        Matrix_Row = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_sready", 64'(sReady), 64'd0);
        check("rst_valid", 64'(mData_valid), 64'd0);
        check("rst_payload", mData_payload, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 14x14x32, word k = k; pin the model with hand-derived positions
        for (int k = 0; k < 784; k++) in_words[k] = 64'(k);
        build_expected(4, 196);
        check("model_out0", exp_q[0], 64'd0);
        check("model_out4", exp_q[4], 64'd1);
        check("model_out1", exp_q[1], 64'd196);
        check("model_out783", exp_q[783], 64'd783);
        check("model_out5", exp_q[5], 64'd197);
        run_layer(32, 14, 14, 1'b0, 1'b0, -1, -1);

        // 2x2x8: identity order, sReady drops after the 4th word
        in_words[0] = 64'hA1A2_A3A4_A5A6_A7A8;
        in_words[1] = 64'hB1B2_B3B4_B5B6_B7B8;
        in_words[2] = 64'hC1C2_C3C4_C5C6_C7C8;
        in_words[3] = 64'hD1D2_D3D4_D5D6_D7D8;
        out_cnt = 0;
        build_expected(1, 4);
        check("model_small0", exp_q[0], 64'hA1A2_A3A4_A5A6_A7A8);
        check("model_small3", exp_q[3], 64'hD1D2_D3D4_D5D6_D7D8);
        pulse_start(8, 2, 2);
        send_words(4, 1'b0, -1);
        sValid = 1'b1;
        sData  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        check("sready_after_4th", 64'(sReady), 64'd0);
        tick();
        @(negedge clk);
        check("sready_extra_beat", 64'(sReady), 64'd0);
        tick();
        sValid = 1'b0;
        wait_drain(4, -1);

        // Backpressure on the big layer
        for (int k = 0; k < 784; k++) in_words[k] = 64'(k);
        run_layer(32, 14, 14, 1'b0, 1'b1, -1, -1);

        // sValid gaps during fill
        run_layer(32, 14, 14, 1'b1, 1'b0, -1, -1);

        // start pulsed mid-fill and mid-drain
        run_layer(32, 14, 14, 1'b0, 1'b0, 300, 50);

        // Reset after 100 input words, then a fresh 2x2x8 layer
        exp_q.delete();
        pulse_start(32, 14, 14);
        send_words(100, 1'b0, -1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_sready", 64'(sReady), 64'd0);
        check("midrst_valid", 64'(mData_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        in_words[0] = 64'h0102_0304_0506_0708;
        in_words[1] = 64'h1112_1314_1516_1718;
        in_words[2] = 64'h2122_2324_2526_2728;
        in_words[3] = 64'h3132_3334_3536_3738;
        run_layer(8, 2, 2, 1'b0, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
